priority_enc_n_rr_v: RTL
========================

# priority_enc_n_rr_v

Registered, parametrised N-input priority encoder with sticky pending latches, per-line masking, a valid/ready output handshake and selectable fixed or round-robin priority. It collects single-cycle request pulses from N sources and presents one encoded winner at a time to a downstream consumer. The block is the sequential, generalised successor to the 4-to-2 combinational priority encoders, and is intended for interrupt and service-request arbitration in the datapath.

## Interface
- N, default 8: number of request lines; legal range 2..64.
- RR, default 0: 0 = fixed priority (line 0 highest); 1 = round-robin.
- W (localparam) = max(1, clog2(N)): code width.

- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req  in  N  request pulses; bit k high for one cycle sets pending[k].
- i_mask  in  N  bit k high makes line k ineligible; its pending bit is kept.
- i_ready  in  1  consumer accepts the presented code this cycle.
- o_code  out  W  encoded index of the presented line.
- o_valid  out  1  o_code is valid and waiting for acceptance.
- o_pending  out  N  current pending register, for status/debug.

## Operation
- Pending register: pending_next = (pending & ~clr) | i_req, where clr is one-hot of o_code when o_valid & i_ready, else 0. A request on the line being accepted in the same cycle keeps that bit set.
- Eligible vector: elig = pending & ~clr & ~i_mask.
- Winner, fixed mode: lowest set index of elig.
- Winner, round-robin mode: first set index of elig searching upward from ptr, wrapping from N-1 to 0. ptr resets to 0 and loads (accepted index + 1) mod N on each handshake. For non-power-of-two N, index N-1 wraps to 0.
- Output FSM, two states:
  - IDLE (o_valid=0): if elig != 0, load o_code with the winner and go to PRESENT; otherwise stay.
  - PRESENT (o_valid=1): if i_ready, handshake occurs. Load the next winner if elig != 0 (stay PRESENT), else go to IDLE. If !i_ready, hold o_code unchanged.
- Stability: while PRESENT and not accepted, o_code does not change. Higher-priority arrivals, a mask set on the presented line, and ptr changes have no effect on it.
- Requests on already-pending lines are absorbed; there is no counting.
- i_req on a masked line still sets pending; the line becomes eligible once unmasked.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge): pending=0, o_valid=0, o_code=0, ptr=0. Reset asserted mid-handshake discards all pending requests and the presented code.
- Request latency: i_req at edge t sets pending after t. With the FSM IDLE, o_valid and o_code are valid after edge t+1, so latency is 2 cycles.
- Throughput: one grant per cycle while eligible lines remain, with i_ready held high.
- The i_ready-to-next-code path is registered. o_code and o_valid are flop outputs with no combinational path from inputs.
- o_pending reflects the register, so it is 1 cycle after i_req.

## Test plan
- Reset and idle (N=8, RR=0): assert i_rst mid-run with pending=8'hFF. Required: o_valid=0, o_code=0 and o_pending=0 immediately; all stay 0 after release with no requests.
- Fixed priority drain (N=8, RR=0, i_ready=1): i_req=8'b1010_0100 for one cycle. Required: o_valid high 2 cycles later; o_code sequence 2, 5, 7 on consecutive cycles; o_valid then drops.
- Hold under backpressure: i_ready=0, pulse i_req[6] so o_code=6 is presented, then pulse i_req[0]. Required: o_code stays 6 until i_ready=1. The next code is 0.
- Round-robin fairness (N=8, RR=1): keep i_req=8'h11 every cycle with i_ready=1. Required: o_code alternates 0, 4, 0, 4, with no line starved.
- Masking (N=5, RR=1): pending lines 1 and 3, with i_mask[1]=1. Required: only 3 is granted, and o_pending keeps bit 1. Clearing the mask then grants 1. Wrap check: last grant 4 followed by a request on line 0 yields code 0.
- Same-cycle re-request: pulse i_req[2] on the cycle line 2 is accepted. Required: pending[2] remains 1 and line 2 is presented again.

Source files
------------

// File: rtl/priority_enc_n_rr_v_if.sv
// Request/grant bundle for priority_enc_n_rr_v: request and mask lines in,
// registered winner code with valid/ready handshake and pending status out.
interface priority_enc_n_rr_v_if #(
  parameter int N = 8
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] i_req;
  logic [N-1:0] i_mask;
  logic         i_ready;
  logic [W-1:0] o_code;
  logic         o_valid;
  logic [N-1:0] o_pending;

  modport master (
    output i_req, i_mask, i_ready,
    input  o_code, o_valid, o_pending
  );

  modport slave (
    input  i_req, i_mask, i_ready,
    output o_code, o_valid, o_pending
  );
endinterface

// File: rtl/priority_enc_n_rr_v.sv
// Registered N-input priority encoder with sticky pending latches, per-line
// masking, valid/ready output handshake and fixed or round-robin priority.
module priority_enc_n_rr_v #(
  parameter int N  = 8,
  parameter int RR = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  priority_enc_n_rr_v_if.slave  io_bus
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  state_t       r_state, w_state_next;
  logic [N-1:0] r_pending, w_pending_next;
  logic [W-1:0] r_code, w_code_next;
  logic [W-1:0] r_ptr, w_ptr_next;
  logic [N-1:0] w_clr, w_elig;
  logic         w_hs;
  logic         w_found;
  logic [W-1:0] w_win;
  logic [W:0]   w_idx;

  assign w_hs = (r_state == S_PRESENT) && io_bus.i_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_clr
      assign w_clr[gi] = w_hs && (r_code == W'(gi));
    end
  endgenerate

  // The accepted line is excluded from eligibility in its own handshake cycle,
  // but a fresh request on it re-arms the pending bit.
  assign w_pending_next = (r_pending & ~w_clr) | io_bus.i_req;
  assign w_elig         = r_pending & ~w_clr & ~io_bus.i_mask;

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_hs) begin
      w_ptr_next = (r_code == W'(N - 1)) ? '0 : r_code + W'(1);
    end
  end

  // Round-robin searches from the post-handshake pointer so the line just
  // served becomes the lowest priority for the very next pick.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (RR != 0) begin
        w_idx = {1'b0, w_ptr_next} + (W+1)'(i);
        if (w_idx >= (W+1)'(N)) begin
          w_idx = w_idx - (W+1)'(N);
        end
      end else begin
        w_idx = (W+1)'(i);
      end
      if (!w_found && w_elig[w_idx[W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[W-1:0];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_code_next  = w_win;
          w_state_next = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (io_bus.i_ready) begin
          if (w_found) begin
            w_code_next = w_win;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_code    <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_code    <= w_code_next;
      r_ptr     <= w_ptr_next;
    end
  end

  assign io_bus.o_code    = r_code;
  assign io_bus.o_valid   = (r_state == S_PRESENT);
  assign io_bus.o_pending = r_pending;
endmodule
